// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one operand bit per cycle, with divide-by-zero/overflow resolved at accept.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_out_result;

  logic               w_accept;
  logic               w_a_signed, w_b_signed;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic               w_div_zero, w_div_ovf, w_special;
  logic [WIDTH-1:0]   w_special_res;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH:0]     w_rem_new;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_final;

  assign w_accept = in_valid && (r_state == IDLE) && !flush;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'd2:    w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg = w_a_signed & a[WIDTH-1];
  assign w_b_neg = w_b_signed & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  assign w_div_zero    = op[2] && (b == '0);
  assign w_div_ovf     = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
  assign w_special     = w_div_zero || w_div_ovf;
  assign w_special_res = w_div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  // One iteration of either algorithm on the shared {hi, lo} accumulator.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + ({1'b0, r_b} & {(WIDTH+1){r_acc[0]}});
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_new = w_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
  assign w_acc_nxt = r_op[2] ? {w_rem_new[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge}
                             : {w_mul_sum, r_acc[WIDTH-1:1]};

  assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quo  = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    case (r_op)
      3'd0:       w_final = w_prod[WIDTH-1:0];
      3'd4, 3'd5: w_final = w_quo;
      3'd6, 3'd7: w_final = w_rem;
      default:    w_final = w_prod[2*WIDTH-1:WIDTH];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (r_count == '0) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state != IDLE);
    out_valid = (r_state == DONE);
  end

  assign out_result = r_out_result;

  // NOTE: datapath registers are reset too, so idle outputs never carry X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_b          <= '0;
      r_acc        <= '0;
      r_count      <= '0;
      r_out_result <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        r_op    <= op;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_b     <= w_b_mag;
        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
        r_count <= CNT_W'(WIDTH - 1);
        if (w_special) r_out_result <= w_special_res;
      end else if (r_state == CALC) begin
        r_acc   <= w_acc_nxt;
        r_count <= r_count - 1'b1;
        if (r_count == '0) r_out_result <= w_final;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, model-checked random ops,
// backpressure, flush and mid-op reset sequences, with a scoreboard queue of expected results.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] sb[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] xs, xu, ys, yu, p;
    logic ovf;
    xs  = {{32{x[31]}}, x};
    xu  = {32'b0, x};
    ys  = {{32{y[31]}}, y};
    yu  = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = xu * yu; return p[31:0]; end
      3'd1: begin p = xs * ys; return p[63:32]; end
      3'd2: begin p = xs * yu; return p[63:32]; end
      3'd3: begin p = xu * yu; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Edges counted from the accept edge (inclusive) to the edge that raises out_valid.
  function automatic int exp_lat(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return W + 1;
  endfunction

  task automatic do_op(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp, input int hold);
    int lat;
    logic [W-1:0] held, want;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; op = f; a = x; b = y;
    @(posedge clk);
    sb.push_back(exp);
    #1;
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    check("busy_after_accept", {in_ready, busy}, 2'b01);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, exp_lat(f, x, y));
    held = out_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_result", out_result, held);
    end
    want = (sb.size() > 0) ? sb.pop_front() : ~out_result;
    check($sformatf("result op%0d %h,%h", f, x, y), out_result, want);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic saw_valid;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

    #12;
    check("reset_state", {in_ready, busy, out_valid, out_result}, {3'b100, 32'h0});
    @(negedge clk); rst = 1'b0;

    // Vector 2 is held under 5 cycles of backpressure; vector 3 follows it.
    for (int i = 0; i < 12; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, (i == 2) ? 5 : 0);

    for (int i = 0; i < 16; i++) begin
      logic [2:0] f;
      logic [W-1:0] x, y;
      f = 3'(i % 8);
      x = $urandom;
      y = (i % 3 == 0) ? W'($urandom_range(0, 5)) : $urandom;
      if (i % 5 == 1) y = -y;
      do_op(f, x, y, model(f, x, y), 0);
    end

    // Flush at cycle 10 of CALC: straight to IDLE, no result.
    @(negedge clk); in_valid = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("flush_to_idle", {busy, out_valid, in_ready}, 3'b001);
    check("flush_accept_blocked", busy, 1'b0);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw_valid |= out_valid | busy;
    end
    check("flush_no_result", saw_valid, 1'b0);

    // Reset mid-CALC returns every output to its reset value at once.
    @(negedge clk); in_valid = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_mid_calc", {in_ready, busy, out_valid, out_result}, {3'b100, 32'h0});
    @(negedge clk); rst = 1'b0;
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
